// File: rtl/bcd_pkg.sv
// Shared BCD constants, sequencer state type and a digit validity helper.
// Used by bcd_digit_add and bcd_serial_adder.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_CORR    = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: a + b + carry-in with +6 decimal correction.
// Out-of-range digits follow the same rule, so the result is always defined.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_t;

    always_comb begin
        w_t     = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
        o_carry = (w_t > {1'b0, BCD_MAX});
        // (t + 6) mod 16 is the same as adding 6 to the low nibble only
        o_digit = o_carry ? (w_t[3:0] + BCD_CORR) : w_t[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one digit pair per clock, LS digit first.
// Optional non-BCD operand flag o_bcd_err when BCD_SERIAL_ADDER_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for i_start; sum/cout hold the previous result
// RUN   | adding digit r_idx each clock, carry rippled in r_carry
// DONE  | one cycle after the last digit; done pulse drops, back to IDLE
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_cout
`ifdef BCD_SERIAL_ADDER_CHECK_EN
    ,
    output logic                  o_bcd_err
`endif
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_sum;
    logic                r_cout;
    logic                r_busy;
    logic                r_done;

    logic [3:0] w_a_d;
    logic [3:0] w_b_d;
    logic [3:0] w_digit;
    logic       w_carry;

    assign w_a_d = r_a[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W];
    assign w_b_d = r_b[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W];

    bcd_digit_add u_digit_add (
        .i_a     (w_a_d),
        .i_b     (w_b_d),
        .i_cin   (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

`ifdef BCD_SERIAL_ADDER_CHECK_EN
    logic r_err;
    assign o_bcd_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_err <= 1'b0;
        end else if (r_state == RUN) begin
            r_err <= r_err | digit_invalid(w_a_d) | digit_invalid(w_b_d);
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W] <= w_digit;
                    r_carry <= w_carry;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule
